// File: rtl/axis_fifo_bp_if.sv
// Stream bundle (data, user, last, valid/ready) used on both sides of axis_fifo_bp.
interface axis_fifo_bp_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_fifo_bp.sv
// AXI-Stream FIFO: IN_MUX-lane input packing, back-pressure, registered FWFT output, drop stats.
// Optional store-and-forward mode: define AXIS_FIFO_BP_PKT_MODE_EN.
module axis_fifo_bp #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned FIFO_LEN        = 16,
    parameter int unsigned IN_MUX          = 1,
    parameter int unsigned ALMOST_FULL_LVL = 12,
    parameter int unsigned DROP_ON_FULL    = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    axis_fifo_bp_if.slave                s_axis_in,
    output logic                         s_axis_in_talmost_full,
    axis_fifo_bp_if.master               m_axis_out,
    output logic [$clog2(FIFO_LEN):0]    m_axis_out_tlevel,
    output logic                         m_axis_out_tempty,
    output logic [15:0]                  drop_cnt_o,
    input  logic                         clear_drop_i
);
    localparam int unsigned PTR_W  = $clog2(FIFO_LEN);
    localparam int unsigned UW     = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int unsigned WORD_W = DATA_WIDTH + UW + 1;

    // Stored word layout: {tlast, tuser, tdata}
    logic [WORD_W-1:0] mem [FIFO_LEN];
    logic [WORD_W-1:0] in_word [IN_MUX];
    logic [WORD_W-1:0] head_word;
    logic [UW*IN_MUX-1:0] in_user;

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              in_ready_q, in_ready_d;
    logic              afull_q, afull_d;
    logic              empty_q, empty_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic [15:0]       drop_q, drop_d;
    logic              wr_en, rd_en, drop_ev;

`ifdef AXIS_FIFO_BP_PKT_MODE_EN
    logic [PTR_W:0]    pkt_cnt_q, pkt_cnt_d;
    logic [PTR_W:0]    pkt_start_q, pkt_start_d;
    logic              discard_q, discard_d;
`endif

    generate
        if (USER_WIDTH > 0) begin : g_user
            assign in_user           = s_axis_in.tuser;
            assign m_axis_out.tuser  = out_word_q[DATA_WIDTH +: UW];
        end else begin : g_no_user
            assign in_user           = '0;
            assign m_axis_out.tuser  = '0;
        end
    endgenerate

    // Lane 0 is stored first; tlast belongs to the last lane only.
    always_comb begin
        for (int i = 0; i < int'(IN_MUX); i++) begin
            in_word[i] = {(i == int'(IN_MUX) - 1) ? s_axis_in.tlast : 1'b0,
                          in_user[i*UW +: UW],
                          s_axis_in.tdata[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    assign head_word = mem[rd_ptr_q[PTR_W-1:0]];

    // Next-state: pointers, output stage, status flags and drop counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        drop_d      = drop_q;
        wr_en       = s_axis_in.tvalid && in_ready_q;
        drop_ev     = (DROP_ON_FULL != 0) && s_axis_in.tvalid && !in_ready_q;
        rd_en       = (level_q != '0) && (!out_valid_q || m_axis_out.tready);
`ifdef AXIS_FIFO_BP_PKT_MODE_EN
        pkt_cnt_d   = pkt_cnt_q;
        pkt_start_d = pkt_start_q;
        discard_d   = discard_q;
        wr_en       = s_axis_in.tvalid && in_ready_q && !discard_q;
        drop_ev     = (DROP_ON_FULL != 0) && s_axis_in.tvalid && !in_ready_q && !discard_q;
        // Cut-through release when an incomplete packet has filled memory.
        rd_en       = (level_q != '0) && (!out_valid_q || m_axis_out.tready) &&
                      ((pkt_cnt_q != '0) || ((DROP_ON_FULL == 0) && !in_ready_q));
`endif

        if (wr_en) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(IN_MUX);
        if (rd_en) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);

`ifdef AXIS_FIFO_BP_PKT_MODE_EN
        if (wr_en && s_axis_in.tlast) pkt_start_d = wr_ptr_d;
        if (drop_ev) begin
            wr_ptr_d  = pkt_start_q;
            discard_d = !s_axis_in.tlast;
        end else if (discard_q && s_axis_in.tvalid && s_axis_in.tlast) begin
            discard_d = 1'b0;
        end
        pkt_cnt_d = pkt_cnt_q + (PTR_W+1)'(wr_en && s_axis_in.tlast)
                              - (PTR_W+1)'(rd_en && head_word[WORD_W-1]);
`endif

        level_d    = wr_ptr_d - rd_ptr_d;
        in_ready_d = (FIFO_LEN - 32'(level_d)) >= IN_MUX;
        afull_d    = 32'(level_d) >= ALMOST_FULL_LVL;

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_word_d  = head_word;
        end else if (m_axis_out.tready) begin
            out_valid_d = 1'b0;
        end
        empty_d = (level_d == '0) && !out_valid_d;

        if (clear_drop_i)                        drop_d = '0;
        else if (drop_ev && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            drop_q      <= drop_d;
        end
    end

`ifdef AXIS_FIFO_BP_PKT_MODE_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pkt_cnt_q   <= '0;
            pkt_start_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_start_q <= pkt_start_d;
            discard_q   <= discard_d;
        end
    end
`endif

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < int'(IN_MUX); i++) begin
                mem[PTR_W'(wr_ptr_q[PTR_W-1:0] + PTR_W'(i))] <= in_word[i];
            end
        end
    end

    assign s_axis_in.tready        = in_ready_q;
    assign s_axis_in_talmost_full  = afull_q;
    assign m_axis_out.tdata        = out_word_q[DATA_WIDTH-1:0];
    assign m_axis_out.tlast        = out_word_q[WORD_W-1];
    assign m_axis_out.tvalid       = out_valid_q;
    assign m_axis_out_tlevel       = level_q;
    assign m_axis_out_tempty       = empty_q;
    assign drop_cnt_o              = drop_q;
endmodule

// File: tb/tb_axis_fifo_bp.sv
// Randomized scoreboard bench for axis_fifo_bp (IN_MUX=2, DROP_ON_FULL=1, cut-through build).
module tb_axis_fifo_bp;
    localparam int unsigned DW  = 16;
    localparam int unsigned UW  = 1;
    localparam int unsigned LEN = 16;
    localparam int unsigned IM  = 2;
    localparam int unsigned AF  = 12;

    typedef logic [DW+UW:0] word_t;   // {last, user, data}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_fifo_bp_if #(.DATA_W(DW*IM), .USER_W(UW*IM)) s_if ();
    axis_fifo_bp_if #(.DATA_W(DW),    .USER_W(UW))    m_if ();
    logic        afull, tempty, clear_drop;
    logic [4:0]  tlevel;
    logic [15:0] drop_cnt;

    axis_fifo_bp #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_LEN(LEN), .IN_MUX(IM),
        .ALMOST_FULL_LVL(AF), .DROP_ON_FULL(1)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .s_axis_in(s_if.slave), .s_axis_in_talmost_full(afull),
        .m_axis_out(m_if.master), .m_axis_out_tlevel(tlevel),
        .m_axis_out_tempty(tempty), .drop_cnt_o(drop_cnt), .clear_drop_i(clear_drop)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy count, output-stage flag, drop count; expected words in exp_q.
    word_t exp_q[$];
    int    mdl_lvl  = 0;
    bit    mdl_ov   = 1'b0;
    int    mdl_drop = 0;

    always @(negedge clk) begin
        bit acc, ld;
        if (!rst_n) begin
            exp_q.delete();
            mdl_lvl = 0; mdl_ov = 1'b0; mdl_drop = 0;
        end else begin
            chk("level",       32'(tlevel),      32'(mdl_lvl));
            chk("in_tready",   32'(s_if.tready), 32'((LEN - mdl_lvl) >= IM));
            chk("almost_full", 32'(afull),       32'(mdl_lvl >= AF));
            chk("tempty",      32'(tempty),      32'(mdl_lvl == 0 && !mdl_ov));
            chk("out_tvalid",  32'(m_if.tvalid), 32'(mdl_ov));
            chk("drop_cnt",    32'(drop_cnt),    32'(mdl_drop));
            acc = s_if.tvalid && ((LEN - mdl_lvl) >= IM);
            ld  = (mdl_lvl > 0) && (!mdl_ov || m_if.tready);
            if (ld)                       mdl_ov = 1'b1;
            else if (mdl_ov && m_if.tready) mdl_ov = 1'b0;
            mdl_lvl = mdl_lvl - int'(ld) + (acc ? IM : 0);
            if (acc) begin
                for (int i = 0; i < IM; i++) begin
                    exp_q.push_back({(i == IM - 1) ? s_if.tlast : 1'b0,
                                     s_if.tuser[i*UW +: UW], s_if.tdata[i*DW +: DW]});
                end
            end
            if (clear_drop)                          mdl_drop = 0;
            else if (s_if.tvalid && !acc && mdl_drop < 65535) mdl_drop++;
        end
    end

    // Monitor: every word leaving the FIFO is popped and compared.
    always @(negedge clk) begin
        word_t w;
        if (rst_n && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(m_if.tdata), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("out_tdata", 32'(m_if.tdata), 32'(w[DW-1:0]));
                chk("out_tuser", 32'(m_if.tuser), 32'(w[DW +: UW]));
                chk("out_tlast", 32'(m_if.tlast), 32'(w[DW+UW]));
            end
        end
    end

    // Source state: a beat stays pending until taken (honour) or is offered once (drop source).
    logic [15:0]       src_cnt = 16'h0001;
    bit                pend = 1'b0;
    int                acc_beats = 0;
    logic [DW*IM-1:0]  cur_data;
    logic [UW*IM-1:0]  cur_user;
    logic              cur_last;

    task automatic cycle(input bit want, input bit rdy, input bit last_in, input bit honour,
                         input bit clr);
        @(posedge clk); #1;
        if (!pend && want) begin
            pend     = 1'b1;
            cur_last = last_in;
            cur_user = UW*IM'($urandom);
            for (int i = 0; i < IM; i++) cur_data[i*DW +: DW] = src_cnt + 16'(i);
        end
        s_if.tvalid  = pend;
        s_if.tdata   = cur_data;
        s_if.tuser   = cur_user;
        s_if.tlast   = cur_last;
        m_if.tready  = rdy;
        clear_drop   = clr;
        @(negedge clk);
        if (pend && (s_if.tready || !honour)) begin
            if (s_if.tready) acc_beats++;
            pend    = 1'b0;
            src_cnt = src_cnt + 16'(IM);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && !(tempty && !pend); i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("drained_empty", 32'(tempty), 32'd1);
    endtask

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0; clear_drop = 1'b0;
        cur_data = '0; cur_user = '0; cur_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tdata",  32'(m_if.tdata),  32'd0);
        chk("rst_tlast",  32'(m_if.tlast),  32'd0);
        chk("rst_tempty", 32'(tempty),      32'd1);
        chk("rst_tready", 32'(s_if.tready), 32'd1);
        chk("rst_afull",  32'(afull),       32'd0);
        chk("rst_level",  32'(tlevel),      32'd0);
        chk("rst_drop",   32'(drop_cnt),    32'd0);
        rst_n = 1'b1;

        // Packing: lanes {0x0002,0x0001} with tlast -> 0x0001 (last=0), then 0x0002 (last=1)
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pack_empty", 32'(tempty), 32'd1);

        // Unread fill with a source that ignores tready: 8 beats stored, 12 dropped
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fill_drop_cnt", 32'(drop_cnt),    32'd12);
        chk("fill_level",    32'(tlevel),      32'd15);
        chk("fill_afull",    32'(afull),       32'd1);
        chk("fill_tready",   32'(s_if.tready), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_drop", 32'(drop_cnt), 32'd0);
        drain();

        // Sink stall of 5 cycles with data held in the output register
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Continuous stream of 100 words with pointer wrap
        src_cnt = 16'h0100;
        acc_beats = 0;
        for (int i = 0; i < 300 && acc_beats < 50; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("stream_beats", 32'(acc_beats), 32'd50);
        drain();

        // Random traffic, mixing honouring and drop-style sources
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
        end

        // Reset mid-stream clears the output stage without waiting for a clock edge
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("async_rst_level",  32'(tlevel),      32'd0);
        chk("async_rst_tempty", 32'(tempty),      32'd1);
        pend = 1'b0; s_if.tvalid = 1'b0; clear_drop = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0, 1'b1, 1'b1, 1'b0);
        end
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
